// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute-stage ALU with EX/MEM result register, N/Z/V flags and two-cycle RED FSM
module alu_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ALUA,
  input  logic [15:0] ALUB,
  input  logic [6:0]  ALUop,
  input  logic [1:0]  flag_mode,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush,
  output logic        busy,
  output logic [15:0] alu_out_MEM,
  output logic        valid_out,
  output logic        flag_N,
  output logic        flag_Z,
  output logic        flag_V
);
  typedef enum logic {IDLE, RED2} state_t;
  state_t state, state_nx;
  logic [1:0]  out_sel, shift_op, red_mode, m_w;
  logic        sat, red, sub, accept, red_op, wr, ovf, v_w;
  logic [16:0] sum;
  logic [15:0] add_res, padd, shf, alu_res, red_res, res_w;
  logic [8:0]  s_hi, s_lo;
  logic [9:0]  red_sum;
  assign {out_sel, sat, red, sub, shift_op} = ALUop;
  assign busy    = state == RED2;
  assign accept  = valid_in & ~busy & ~stall_in & ~flush;
  assign red_op  = out_sel == 2'b00 && red;
  assign wr      = busy | (accept & ~red_op);
  assign sum     = {1'b0, ALUA} + {1'b0, ALUB} + {16'h0, sub};
  assign ovf     = (ALUA[15] == ALUB[15]) && (sum[15] != ALUA[15]);
  assign add_res = (flag_mode == 2'b11 && ovf) ? (ALUA[15] ? 16'h8000 : 16'h7FFF) : sum[15:0];
  for (genvar i = 0; i < 4; i++) begin : g_nib
    logic [4:0] ns;
    assign ns = {ALUA[4*i+3], ALUA[4*i+3:4*i]} + {ALUB[4*i+3], ALUB[4*i+3:4*i]};
    assign padd[4*i+3:4*i] = (ns[4] ^ ns[3]) ? {ns[4], {3{~ns[4]}}} : ns[3:0];
  end
  assign red_sum = {s_hi[8], s_hi} + {s_lo[8], s_lo};
  assign red_res = {{6{red_sum[9]}}, red_sum};
  // Shifter and result select; ROR takes the low half of a doubled word shifted right
  always_comb begin
    shf = (shift_op == 2'b00) ? ALUA << ALUB[3:0] :
          (shift_op == 2'b01) ? 16'($signed(ALUA) >>> ALUB[3:0]) :
          (shift_op == 2'b10) ? 16'({ALUA, ALUA} >> ALUB[3:0]) : ALUA;
    alu_res = (out_sel == 2'b01) ? ALUA ^ ALUB :
              (out_sel == 2'b10) ? shf :
              (out_sel == 2'b11) ? 16'h0000 :
              sat ? padd : add_res;
    res_w = busy ? red_res : alu_res;
    m_w   = busy ? red_mode : flag_mode;
    v_w   = ~busy && out_sel == 2'b00 && !sat && !red && ovf;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: flush always returns to IDLE, stall freezes the FSM
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (!stall_in) state_nx = (!busy && accept && red_op) ? RED2 : IDLE;
  end
  // EX/MEM result, valid, flags and RED partial sums
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_out_MEM <= 16'h0000;
      valid_out   <= 1'b0;
      flag_N      <= 1'b0;
      flag_Z      <= 1'b0;
      flag_V      <= 1'b0;
      s_hi        <= 9'h0;
      s_lo        <= 9'h0;
      red_mode    <= 2'b00;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (!stall_in) begin
      valid_out <= wr;
      if (wr) alu_out_MEM <= res_w;
      if (wr && m_w[0]) flag_Z <= res_w == 16'h0000;
      if (wr && m_w == 2'b11) begin
        flag_N <= res_w[15];
        flag_V <= v_w;
      end
      if (accept && red_op) begin
        s_hi     <= {ALUA[15], ALUA[15:8]} + {ALUB[15], ALUB[15:8]};
        s_lo     <= {ALUA[7], ALUA[7:0]} + {ALUB[7], ALUB[7:0]};
        red_mode <= flag_mode;
      end
    end
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed-vector self-checking bench for alu_ex_stage
module tb_alu_ex_stage;
  logic        clk = 0, rst_n = 0;
  logic [15:0] a = 0, b = 0;
  logic [6:0]  op = 0;
  logic [1:0]  mode = 0;
  logic        vin = 0, stall = 0, fl = 0;
  logic        busy, vout, n, z, v;
  logic [15:0] out;
  int total = 0, bad = 0;
  localparam logic [6:0] ADD = 7'h00, SUB = 7'h04, PADD = 7'h10, RED = 7'h08,
    XOR = 7'h20, ZERO = 7'h60, SLL = 7'h40, SRA = 7'h41, ROR = 7'h42, PASS = 7'h43;
  alu_ex_stage dut (.clk(clk), .rst_n(rst_n), .ALUA(a), .ALUB(b), .ALUop(op),
    .flag_mode(mode), .valid_in(vin), .stall_in(stall), .flush(fl), .busy(busy),
    .alu_out_MEM(out), .valid_out(vout), .flag_N(n), .flag_Z(z), .flag_V(v));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [6:0] iop, input logic [1:0] im);
    a = ia; b = ib; op = iop; mode = im; vin = 1;
    step();
    vin = 0;
  endtask
  task automatic flags(input string tag, input logic en, input logic ez, input logic ev);
    check({tag, "_nzv"}, {13'h0, n, z, v}, {13'h0, en, ez, ev});
  endtask
  initial begin
    #12;
    check("rst_out", out, 16'h0000);
    check("rst_vld", {15'h0, vout}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    flags("rst", 0, 0, 0);
    rst_n = 1;
    @(negedge clk);
    issue(16'h7FF0, 16'h0020, ADD, 2'b11);
    check("add_sat", out, 16'h7FFF); check("add_sat_vld", {15'h0, vout}, 16'h1); flags("add_sat", 0, 0, 1);
    issue(16'h0005, 16'hFFFA, SUB, 2'b11);
    check("sub", out, 16'h0000); flags("sub", 0, 1, 0);
    issue(16'h0001, 16'h0001, ADD, 2'b00);
    check("add_m0", out, 16'h0002); flags("add_m0", 0, 1, 0);
    issue(16'h7823, 16'h1F11, PADD, 2'b00);
    check("paddsb", out, 16'h7834); flags("paddsb", 0, 1, 0);
    issue(16'h1234, 16'h5678, RED, 2'b00);
    check("red_c1_vld", {15'h0, vout}, 16'h0); check("red_c1_busy", {15'h0, busy}, 16'h1);
    step();
    check("red_out", out, 16'h0114); check("red_vld", {15'h0, vout}, 16'h1);
    check("red_busy_off", {15'h0, busy}, 16'h0);
    issue(16'h7FF0, 16'h0020, ADD, 2'b00);
    check("add_wrap", out, 16'h8010); flags("add_wrap", 0, 1, 0);
    issue(16'hFF80, 16'hFF80, RED, 2'b11);
    stall = 1; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("red_stall_busy", {15'h0, busy}, 16'h1);
      check("red_stall_vld", {15'h0, vout}, 16'h0);
    end
    stall = 0;
    step();
    check("red_neg", out, 16'hFEFE); check("red_neg_vld", {15'h0, vout}, 16'h1); flags("red_neg", 1, 0, 0);
    issue(16'h8001, 16'h0004, ROR, 2'b00);
    check("ror", out, 16'h1800);
    issue(16'h8000, 16'h000F, SRA, 2'b00);
    check("sra", out, 16'hFFFF);
    issue(16'h0001, 16'h0000, SLL, 2'b01);
    check("sll0", out, 16'h0001); flags("sll0", 1, 0, 0);
    issue(16'h0003, 16'h0005, SLL, 2'b00);
    check("sll5", out, 16'h0060);
    issue(16'hABCD, 16'h0003, PASS, 2'b00);
    check("pass", out, 16'hABCD);
    issue(16'hF0F0, 16'hFF00, XOR, 2'b11);
    check("xor", out, 16'h0FF0); flags("xor", 0, 0, 0);
    issue(16'h1234, 16'h4321, ZERO, 2'b11);
    check("zero", out, 16'h0000); flags("zero", 0, 1, 0);
    step();
    check("bubble_vld", {15'h0, vout}, 16'h0); check("bubble_out", out, 16'h0000);
    issue(16'h0101, 16'h0101, RED, 2'b11);
    fl = 1;
    step();
    fl = 0;
    check("flush_vld", {15'h0, vout}, 16'h0); check("flush_busy", {15'h0, busy}, 16'h0);
    check("flush_out", out, 16'h0000); flags("flush", 0, 1, 0);
    a = 16'h0001; b = 16'h0001; op = ADD; vin = 1; fl = 1;
    step();
    fl = 0; vin = 0;
    check("flush_in_vld", {15'h0, vout}, 16'h0); check("flush_in_out", out, 16'h0000);
    issue(16'h0003, 16'h0004, ADD, 2'b01);
    check("add_m1", out, 16'h0007); flags("add_m1", 0, 0, 0);
    a = 0; b = 0; vin = 1; stall = 1;
    step();
    check("stall_vld", {15'h0, vout}, 16'h1); check("stall_out", out, 16'h0007);
    stall = 0; vin = 0;
    issue(16'h0010, 16'h0020, RED, 2'b11);
    #3 rst_n = 0;
    #1;
    check("arst_out", out, 16'h0000); check("arst_vld", {15'h0, vout}, 16'h0);
    check("arst_busy", {15'h0, busy}, 16'h0); flags("arst", 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
